// File: rtl/controlador_estados.sv
// controlador_estados: pet behaviour FSM producing the one-hot estado for the
// attribute controller, plus the death pulse and the low-attribute alert.
module controlador_estados #(
  parameter int unsigned TICK_WIDTH    = 23,
  parameter logic [7:0]  MAX_ATRIB     = 8'd100,
  parameter logic [7:0]  GRACE_TICKS   = 8'd10,
  parameter logic [7:0]  LIMIAR_ALERTA = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_dormir,
  input  logic       btn_comer,
  input  logic       btn_aula,
  input  logic [7:0] fome,
  input  logic [7:0] felicidade,
  input  logic [7:0] sono,
  output logic [4:0] estado,
  output logic       morte,
  output logic       alerta
);

  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_t;

  estado_t               estado_r;
  estado_t               estado_next_s;
  logic [TICK_WIDTH-1:0] presc_r;
  logic [7:0]            zero_cnt_r;
  logic [3:0]            btn_q_r;   // {aula, comer, dormir, start}
  logic [3:0]            btn_p_r;
  logic [3:0]            press_s;
  logic                  morte_r;
  logic                  alerta_r;
  logic                  tick_s;
  logic                  zero_s;
  logic                  baixo_s;
  logic                  vivo_s;
  logic                  vivo_next_s;
  logic                  morrer_s;

  assign press_s  = btn_q_r & ~btn_p_r;
  assign tick_s   = (presc_r == {TICK_WIDTH{1'b0}});
  assign zero_s   = (fome == 8'd0) | (felicidade == 8'd0) | (sono == 8'd0);
  assign baixo_s  = (fome < LIMIAR_ALERTA) | (felicidade < LIMIAR_ALERTA) |
                    (sono < LIMIAR_ALERTA);
  assign morrer_s = vivo_s & (zero_cnt_r >= GRACE_TICKS);

  // Classify current and next state as "alive" (one of the four activity states).
  always_comb begin
    vivo_s      = 1'b0;
    vivo_next_s = 1'b0;
    case (estado_r)
      IDLE, DORMINDO, COMENDO, DANDO_AULA: vivo_s = 1'b1;
      default:                             vivo_s = 1'b0;
    endcase
    case (estado_next_s)
      IDLE, DORMINDO, COMENDO, DANDO_AULA: vivo_next_s = 1'b1;
      default:                             vivo_next_s = 1'b0;
    endcase
  end

  // Next-state decision; death overrides every other transition.
  always_comb begin
    estado_next_s = estado_r;
    if (morrer_s) begin
      estado_next_s = MORTO;
    end else begin
      case (estado_r)
        INTRO: begin
          if (press_s[0]) estado_next_s = IDLE;
          else            estado_next_s = INTRO;
        end
        IDLE: begin
          if (press_s[1])      estado_next_s = DORMINDO;
          else if (press_s[2]) estado_next_s = COMENDO;
          else if (press_s[3]) estado_next_s = DANDO_AULA;
          else                 estado_next_s = IDLE;
        end
        DORMINDO: begin
          if ((sono >= MAX_ATRIB) || press_s[0] || press_s[1]) estado_next_s = IDLE;
          else                                                 estado_next_s = DORMINDO;
        end
        COMENDO: begin
          if ((fome >= MAX_ATRIB) || press_s[0] || press_s[2]) estado_next_s = IDLE;
          else                                                 estado_next_s = COMENDO;
        end
        DANDO_AULA: begin
          if ((felicidade >= MAX_ATRIB) || press_s[0] || press_s[3]) estado_next_s = IDLE;
          else                                                       estado_next_s = DANDO_AULA;
        end
        MORTO: begin
          if (press_s[0]) estado_next_s = INTRO;
          else            estado_next_s = MORTO;
        end
        default: estado_next_s = INTRO;  // corrupted encoding recovers here
      endcase
    end
  end

  // State, prescaler, button history, zero-tick counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r   <= INTRO;
      presc_r    <= {TICK_WIDTH{1'b0}};
      zero_cnt_r <= 8'd0;
      btn_q_r    <= 4'b0000;
      btn_p_r    <= 4'b0000;
      morte_r    <= 1'b0;
      alerta_r   <= 1'b0;
    end else begin
      estado_r <= estado_next_s;
      presc_r  <= presc_r + TICK_WIDTH'(1);
      btn_q_r  <= {btn_aula, btn_comer, btn_dormir, btn_start};
      btn_p_r  <= btn_q_r;
      morte_r  <= morrer_s;
      alerta_r <= vivo_next_s & baixo_s;
      // Counter only runs while alive; it saturates at the grace limit.
      if (!vivo_s || morrer_s || !zero_s) begin
        zero_cnt_r <= 8'd0;
      end else if (tick_s && (zero_cnt_r < GRACE_TICKS)) begin
        zero_cnt_r <= zero_cnt_r + 8'd1;
      end else begin
        zero_cnt_r <= zero_cnt_r;
      end
    end
  end

  assign estado = estado_r;
  assign morte  = morte_r;
  assign alerta = alerta_r;

endmodule

// File: doc/controlador_estados.md
Name: controlador_estados

Overview:
- Pet behaviour state machine that produces the 5-bit one-hot `estado` consumed by the attribute controller.
- Consumes that controller's `fome`, `felicidade` and `sono` values plus the player buttons.
- Decides activity entry and exit, death and restart, closing the loop between attribute bookkeeping and the display/animation logic.

Parameters:
- TICK_WIDTH, 23, width of the free-running prescaler; one tick when the counter is all zeros, matching the attribute update rate.
- MAX_ATRIB, 8'd100, attribute value at which an activity is complete.
- GRACE_TICKS, 8'd10, consecutive ticks with any attribute at 0 before death.
- LIMIAR_ALERTA, 8'd20, an attribute strictly below this raises `alerta`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_start  in  1  start / cancel / restart button, level, already debounced
- btn_dormir  in  1  sleep button, level, debounced
- btn_comer  in  1  eat button, level, debounced
- btn_aula  in  1  teach button, level, debounced
- fome  in  8  hunger attribute, 0..100
- felicidade  in  8  happiness attribute, 0..100
- sono  in  8  sleep attribute, 0..100
- estado  out  5  one-hot state: INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000
- morte  out  1  single-cycle pulse on entry to MORTO
- alerta  out  1  registered, high while in IDLE/DORMINDO/COMENDO/DANDO_AULA and any attribute < LIMIAR_ALERTA

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - estado=INTRO, morte=0, alerta=0.
  - Prescaler=0, zero-tick counter=0, button registers=0.
  - rst mid-activity aborts to INTRO immediately with no morte pulse.
- Buttons:
  - Each button is registered into btn_q; the previous btn_q is held in btn_p.
  - press = btn_q & ~btn_p, one cycle per rising edge. Holding a button generates no repeat presses.
  - estado changes on the second rising edge at which the button is sampled high.
- Tick: prescaler increments every cycle and wraps modulo 2^TICK_WIDTH; tick=1 in the cycle where the prescaler is 0. The first tick occurs in the first cycle after reset.
- Death condition:
  - zero = (fome==0) | (felicidade==0) | (sono==0).
  - In non-INTRO, non-MORTO states, the zero-tick counter increments on tick while zero=1 and clears on any cycle where zero=0.
  - When the counter reaches GRACE_TICKS, the next edge enters MORTO: morte=1 for one cycle and the counter clears.
  - The counter saturates and never wraps.
  - Death has the highest priority over every other transition in the same cycle.
- Transitions (evaluated every cycle, not tick-gated; death excepted):
  - INTRO: press start -> IDLE; all other buttons ignored.
  - IDLE: press dormir -> DORMINDO, comer -> COMENDO, aula -> DANDO_AULA.
    - Simultaneous presses resolve by priority dormir > comer > aula.
    - Press start is ignored.
  - DORMINDO: exit to IDLE when sono>=MAX_ATRIB, or on press start, or on press dormir (cancel). Other activity buttons are ignored.
  - COMENDO: same rules with fome / btn_comer.
  - DANDO_AULA: same rules with felicidade / btn_aula.
  - Completion and cancel in the same cycle both go to IDLE; no difference.
  - MORTO: press start -> INTRO; all else ignored. Attributes are not reset by this block.
- Comparisons:
  - All comparisons are unsigned 8-bit.
  - Inputs > MAX_ATRIB count as full.
- estado is always one of the six legal encodings. Any illegal value (e.g. an SEU) recovers to INTRO on the next edge.

Test Plan (TICK_WIDTH=4, GRACE_TICKS=3):
- Reset, then pulse btn_start for 1 cycle -> estado 00000 to 00001 two edges after the button is first sampled high; alerta=0 with all attributes at 50.
- IDLE; btn_dormir and btn_aula asserted in the same cycle -> estado=00010. Then drive sono 97->100 -> estado=00001 on the next edge.
- COMENDO with fome=60; press btn_comer again -> IDLE. Hold btn_aula high for 40 cycles -> exactly one transition to 01000.
- IDLE with felicidade=0 for 3 ticks (48 cycles) -> estado=10000 with a single-cycle morte=1. felicidade returning to 5 after 2 ticks -> no death, counter cleared.
- MORTO; press dormir -> no change. Press start -> INTRO. Assert rst while in DANDO_AULA -> INTRO next edge, morte stays 0.
- fome=19 in IDLE -> alerta=1 next edge; fome=20 -> alerta=0; in INTRO with fome=0 -> alerta=0 and no death.
